// File: rtl/seg7_reader_if.sv
// Signal bundle between a scanned 7-segment display driver and its reader.
// The driver side owns seg/an/clr_err; the reader side owns the recovered state.
interface seg7_reader_if #(
   parameter int N_DIGITS = 4
);
   logic [6:0]            seg;
   logic [N_DIGITS-1:0]   an;
   logic                  clr_err;
   logic [4*N_DIGITS-1:0] digits;
   logic [N_DIGITS-1:0]   valid;
   logic [N_DIGITS-1:0]   blank;
   logic                  err;
   logic                  upd;
   logic [2:0]            upd_idx;

   modport master (
      output seg, an, clr_err,
      input  digits, valid, blank, err, upd, upd_idx
   );

   modport slave (
      input  seg, an, clr_err,
      output digits, valid, blank, err, upd, upd_idx
   );
endinterface

// File: rtl/seg7_reader.sv
// Recovers the BCD digit shown at each position of a multiplexed 7-segment display
// by committing a (seg, an) pair only after it has been stable for STABLE_CYCLES samples.
module seg7_reader #(
   parameter int N_DIGITS      = 4,
   parameter int STABLE_CYCLES = 4
) (
   input  logic          clk,
   input  logic          resetn,
   seg7_reader_if.slave  bus
);
   localparam int RW = $clog2(STABLE_CYCLES + 1);
   localparam int PW = 7 + N_DIGITS;

   if (N_DIGITS < 1 || N_DIGITS > 8) begin : g_bad_n
      $error("seg7_reader: N_DIGITS must be in 1..8");
   end
   if (STABLE_CYCLES < 1) begin : g_bad_sc
      $error("seg7_reader: STABLE_CYCLES must be >= 1");
   end

   logic [PW-1:0]               sync1_q, sync2_q, prev_q;
   logic [RW-1:0]               run_q, run_d;
   logic                        committed_q, committed_d;
   logic [N_DIGITS-1:0][3:0]    digits_q;
   logic [N_DIGITS-1:0]         valid_q, blank_q;
   logic                        err_q, err_d;
   logic                        upd_q;
   logic [2:0]                  upd_idx_q;

   logic [6:0]                  seg_s;
   logic [N_DIGITS-1:0]         an_s;
   logic                        changed, onehot, commit;
   logic [3:0]                  n_low;
   logic [2:0]                  sel_idx;
   logic [3:0]                  dec_val;
   logic                        dec_legal, dec_blank;

   assign {seg_s, an_s} = sync2_q;

   // Run length of the current synchronized pair, saturating at STABLE_CYCLES.
   always_comb begin
      changed = (sync2_q != prev_q);
      if (changed)
         run_d = RW'(1);
      else if (run_q == RW'(STABLE_CYCLES))
         run_d = run_q;
      else
         run_d = run_q + RW'(1);
   end

   always_comb begin
      n_low   = 4'd0;
      sel_idx = 3'd0;
      for (int i = 0; i < N_DIGITS; i++) begin
         if (!an_s[i]) begin
            n_low   = n_low + 4'd1;
            sel_idx = 3'(i);
         end
      end
      onehot = (n_low == 4'd1);
   end

   // A fresh pair may commit even if the previous run already did.
   always_comb begin
      commit      = (run_d == RW'(STABLE_CYCLES)) && (changed || !committed_q) && onehot;
      committed_d = changed ? commit : (committed_q | commit);
   end

   always_comb begin
      dec_val   = 4'd0;
      dec_legal = 1'b1;
      dec_blank = 1'b0;
      unique case (seg_s)
         7'h01: dec_val = 4'd0;
         7'h4F: dec_val = 4'd1;
         7'h12: dec_val = 4'd2;
         7'h06: dec_val = 4'd3;
         7'h4C: dec_val = 4'd4;
         7'h24: dec_val = 4'd5;
         7'h20: dec_val = 4'd6;
         7'h0F: dec_val = 4'd7;
         7'h00: dec_val = 4'd8;
         7'h04: dec_val = 4'd9;
         7'h7F: begin
            dec_legal = 1'b0;
            dec_blank = 1'b1;
         end
         default: dec_legal = 1'b0;
      endcase
   end

   // Set wins over a same-cycle clear.
   always_comb begin
      err_d = err_q;
      if (commit && !dec_legal && !dec_blank)
         err_d = 1'b1;
      else if (bus.clr_err)
         err_d = 1'b0;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sync1_q     <= '1;
         sync2_q     <= '1;
         prev_q      <= '1;
         run_q       <= '0;
         committed_q <= 1'b0;
      end else begin
         sync1_q     <= {bus.seg, bus.an};
         sync2_q     <= sync1_q;
         prev_q      <= sync2_q;
         run_q       <= run_d;
         committed_q <= committed_d;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         digits_q  <= '0;
         valid_q   <= '0;
         blank_q   <= '0;
         err_q     <= 1'b0;
         upd_q     <= 1'b0;
         upd_idx_q <= 3'd0;
      end else begin
         err_q <= err_d;
         upd_q <= commit;
         if (commit)
            upd_idx_q <= sel_idx;
         for (int i = 0; i < N_DIGITS; i++) begin
            if (commit && sel_idx == 3'(i)) begin
               if (dec_legal)
                  digits_q[i] <= dec_val;
               valid_q[i] <= dec_legal;
               blank_q[i] <= dec_blank;
            end
         end
      end
   end

   assign bus.digits  = digits_q;
   assign bus.valid   = valid_q;
   assign bus.blank   = blank_q;
   assign bus.err     = err_q;
   assign bus.upd     = upd_q;
   assign bus.upd_idx = upd_idx_q;
endmodule

// File: tb/tb_seg7_reader.sv
// Directed bench for seg7_reader: stimulus queues expected commits, a monitor
// checks every upd pulse against the queue, including its arrival cycle.
module tb_seg7_reader;
   localparam int N  = 4;
   localparam int SC = 4;
   localparam int K_DIG = 0;
   localparam int K_BLK = 1;
   localparam int K_ILL = 2;

   typedef struct {
      int           cyc;
      int           idx;
      logic [15:0]  dig;
      logic [3:0]   val;
      logic [3:0]   blk;
      logic         err;
   } exp_t;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;
   int   upd_cnt = 0;
   exp_t q[$];
   exp_t me;

   logic [N-1:0][3:0] m_dig;
   logic [N-1:0]      m_val, m_blk;
   logic              m_err;

   seg7_reader_if #(.N_DIGITS(N)) bus ();
   seg7_reader #(.N_DIGITS(N), .STABLE_CYCLES(SC)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model update for a committed vector plus its expected arrival cycle.
   task automatic drive(input logic [N-1:0] a, input logic [6:0] s, input int n,
                        input int kind, input logic [3:0] v);
      int   k;
      int   idx;
      exp_t e;
      @(negedge clk);
      bus.an  = a;
      bus.seg = s;
      k = cyc;
      if ($countones(~a) == 1 && n >= SC) begin
         idx = 0;
         for (int i = 0; i < N; i++) if (!a[i]) idx = i;
         case (kind)
            K_DIG:   begin m_dig[idx] = v; m_val[idx] = 1'b1; m_blk[idx] = 1'b0; end
            K_BLK:   begin m_val[idx] = 1'b0; m_blk[idx] = 1'b1; end
            default: begin m_val[idx] = 1'b0; m_blk[idx] = 1'b0; m_err = 1'b1; end
         endcase
         e.cyc = k + 2 + SC;
         e.idx = idx;
         e.dig = m_dig;
         e.val = m_val;
         e.blk = m_blk;
         e.err = m_err;
         q.push_back(e);
      end
      repeat (n - 1) @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (q.size() > 0 && cyc > q[0].cyc) begin
         me = q.pop_front();
         chk("missing_upd", 32'(cyc), 32'(me.cyc));
      end
      if (bus.upd === 1'b1) begin
         upd_cnt++;
         if (q.size() == 0) begin
            chk("unexpected_upd", 32'(bus.upd_idx), 32'hFFFF_FFFF);
         end else begin
            me = q.pop_front();
            chk("upd_cycle",  32'(cyc),         32'(me.cyc));
            chk("upd_idx",    32'(bus.upd_idx), 32'(me.idx));
            chk("upd_digits", 32'(bus.digits),  32'(me.dig));
            chk("upd_valid",  32'(bus.valid),   32'(me.val));
            chk("upd_blank",  32'(bus.blank),   32'(me.blk));
            chk("upd_err",    32'(bus.err),     32'(me.err));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      exp_t e;
      bus.an = '1;
      bus.seg = 7'h7F;
      bus.clr_err = 1'b0;
      m_dig = '0; m_val = '0; m_blk = '0; m_err = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_digits", 32'(bus.digits), 'h0);
      chk("rst_valid",  32'(bus.valid),  'h0);
      chk("rst_blank",  32'(bus.blank),  'h0);
      chk("rst_err",    32'(bus.err),    'h0);
      chk("rst_upd",    32'(bus.upd),    'h0);
      resetn = 1'b1;

      drive(4'b1110, 7'h12, 10, K_DIG, 4'd2);
      chk("t1_digits", 32'(bus.digits), 'h0002);
      chk("t1_valid",  32'(bus.valid),  'h1);

      c0 = upd_cnt;
      for (int r = 0; r < 2; r++) begin
         drive(4'b1110, 7'h4F, 8, K_DIG, 4'd1);
         drive(4'b1101, 7'h04, 8, K_DIG, 4'd9);
         drive(4'b1011, 7'h06, 8, K_DIG, 4'd3);
         drive(4'b0111, 7'h0F, 8, K_DIG, 4'd7);
      end
      chk("scan_digits", 32'(bus.digits), 'h7391);
      chk("scan_valid",  32'(bus.valid),  'hF);
      chk("scan_upds",   32'(upd_cnt - c0), 'd8);

      drive(4'b1101, 7'h24, 3, K_DIG, 4'd5);
      drive(4'b1101, 7'h20, 10, K_DIG, 4'd6);
      chk("glitch_digits", 32'(bus.digits), 'h7361);

      drive(4'b1011, 7'h7E, 8, K_ILL, 4'd0);
      chk("ill_err",    32'(bus.err),    'h1);
      chk("ill_valid",  32'(bus.valid),  'hB);
      chk("ill_digits", 32'(bus.digits), 'h7361);
      drive(4'b1011, 7'h7F, 8, K_BLK, 4'd0);
      chk("blk_blank", 32'(bus.blank), 'h4);
      chk("blk_err",   32'(bus.err),   'h1);
      @(negedge clk); bus.clr_err = 1'b1;
      @(negedge clk); bus.clr_err = 1'b0; m_err = 1'b0;
      chk("clr_err", 32'(bus.err), 'h0);

      // Clear lands on the same edge as an illegal commit.
      drive(4'b0111, 7'h7E, 5, K_ILL, 4'd0);
      @(negedge clk); bus.clr_err = 1'b1;
      @(negedge clk); bus.clr_err = 1'b0;
      chk("setwins_err", 32'(bus.err), 'h1);
      repeat (2) @(negedge clk);

      c0 = upd_cnt;
      drive(4'b1111, 7'h00, 20, K_DIG, 4'd8);
      drive(4'b1100, 7'h00, 20, K_DIG, 4'd8);
      chk("nosel_upds",   32'(upd_cnt - c0), 'd0);
      chk("nosel_digits", 32'(bus.digits), 32'(m_dig));
      chk("nosel_valid",  32'(bus.valid),  32'(m_val));
      chk("nosel_blank",  32'(bus.blank),  32'(m_blk));
      chk("nosel_err",    32'(bus.err),    32'(m_err));

      @(negedge clk);
      bus.an = 4'b1110;
      bus.seg = 7'h20;
      repeat (3) @(negedge clk);
      resetn = 1'b0;
      #1;
      chk("mrst_digits", 32'(bus.digits), 'h0);
      chk("mrst_valid",  32'(bus.valid),  'h0);
      chk("mrst_blank",  32'(bus.blank),  'h0);
      chk("mrst_err",    32'(bus.err),    'h0);
      chk("mrst_upd",    32'(bus.upd),    'h0);
      @(negedge clk);
      resetn = 1'b1;
      e.cyc = cyc + 2 + SC;
      e.idx = 0;
      e.dig = 16'h0006;
      e.val = 4'b0001;
      e.blk = 4'b0000;
      e.err = 1'b0;
      q.push_back(e);
      repeat (10) @(negedge clk);
      chk("mrst_digits_after", 32'(bus.digits), 'h0006);
      chk("mrst_valid_after",  32'(bus.valid),  'h1);
      chk("queue_drained",     32'(q.size()),   'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
